// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment scan driver and the
// upstream binary-to-segment decode stage.
//   scan_state_t : scan phase within a digit slot (BLANK guard, SHOW lit)
//   SEG_W        : width of one digit's segment pattern
//   SEG_BLANK    : all-segments-off pattern
//   SEG_DIGIT    : hex digit patterns, bit order {a,b,c,d,e,f,g,dp}, 1 = lit
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int SEG_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    localparam logic [SEG_W-1:0] SEG_DIGIT [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] i_val);
        return SEG_DIGIT[i_val];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_timer.sv
// seg7_refresh_timer: free-running slot counter for the scan driver.
//   i_clk              : clock, rising edge
//   i_rst              : synchronous active-high reset, counter to 0
//   o_blank_end        : count is on the last blanking cycle of the slot
//   o_slot_end         : count is on the last cycle of the slot
//   o_slot_end_early   : count is one cycle before the last cycle of the slot
// Counts 0 .. DIV-1 and wraps.
module seg7_refresh_timer
    import seg7_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_blank_end,
    output logic o_slot_end,
    output logic o_slot_end_early
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_blank_end      = (r_cnt == CW'(BLANK_CYC - 1));
    assign o_slot_end       = (r_cnt == CW'(DIV - 1));
    // Lets the parent register outputs that must line up with the slot end.
    assign o_slot_end_early = (r_cnt == CW'(DIV - 2));

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver.
//   Clk       : clock, rising edge
//   Rst       : synchronous active-high reset
//   SegIn     : per-digit patterns, digit k at SegIn[8k+7:8k]
//   LoadValid : SegIn valid
//   LoadReady : pending buffer empty (registered, no path from LoadValid)
//   SegOut    : shared segment bus, active-high
//   DigEn     : one-hot digit enable, all-zero while blanking
//   FrameTick : pulse on the last cycle of the last digit
// Loads land in a pending buffer and are copied to the active buffer only at
// the frame boundary, so a frame never mixes old and new patterns.
//
// state | meaning
// BLANK | guard interval at slot start, all digits off
// SHOW  | digit dig_idx driven with its active pattern
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIG   = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [SEG_W*NUM_DIG-1:0] SegIn,
    input  logic                     LoadValid,
    output logic                     LoadReady,
    output logic [SEG_W-1:0]         SegOut,
    output logic [NUM_DIG-1:0]       DigEn,
    output logic                     FrameTick
);

    localparam int DW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIG - 1);

    logic [SEG_W*NUM_DIG-1:0] r_active;
    logic [SEG_W*NUM_DIG-1:0] r_pending;
    logic                     r_pend_full;
    logic [DW-1:0]            r_dig_idx;
    scan_state_t              r_state;
    logic [SEG_W-1:0]         r_seg_out;
    logic [NUM_DIG-1:0]       r_dig_en;
    logic                     r_frame_tick;

    logic                     w_blank_end;
    logic                     w_slot_end;
    logic                     w_slot_end_early;
    scan_state_t              w_state_nxt;
    logic [DW-1:0]            w_dig_nxt;
    logic                     w_frame_end;
    logic                     w_load_acc;
    logic                     w_tick_nxt;

    seg7_refresh_timer #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .i_clk            (Clk),
        .i_rst            (Rst),
        .o_blank_end      (w_blank_end),
        .o_slot_end       (w_slot_end),
        .o_slot_end_early (w_slot_end_early)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig_idx;
        case (r_state)
            BLANK: begin
                if (w_blank_end) begin
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (w_slot_end) begin
                    w_state_nxt = BLANK;
                    w_dig_nxt   = (r_dig_idx == LAST_DIG) ? '0 : r_dig_idx + DW'(1);
                end
            end
            default: begin
                w_state_nxt = BLANK;
            end
        endcase
    end

    assign w_frame_end = (r_state == SHOW) && w_slot_end && (r_dig_idx == LAST_DIG);
    assign w_load_acc  = LoadValid && !r_pend_full;

    // Outputs are registered from the next state so they line up with it.
    assign w_tick_nxt  = (w_state_nxt == SHOW) && w_slot_end_early && (w_dig_nxt == LAST_DIG);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_full  <= 1'b0;
            r_dig_idx    <= '0;
            r_state      <= BLANK;
            r_seg_out    <= SEG_BLANK;
            r_dig_en     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dig_idx <= w_dig_nxt;

            // Accept and frame-boundary copy are exclusive: accept needs an
            // empty buffer, the copy needs a full one.
            if (w_load_acc) begin
                r_pending   <= SegIn;
                r_pend_full <= 1'b1;
            end else if (w_frame_end && r_pend_full) begin
                r_active    <= r_pending;
                r_pend_full <= 1'b0;
            end

            if (w_state_nxt == SHOW) begin
                r_dig_en  <= NUM_DIG'(1) << w_dig_nxt;
                r_seg_out <= r_active[int'(w_dig_nxt)*SEG_W +: SEG_W];
            end else begin
                r_dig_en  <= '0;
                r_seg_out <= SEG_BLANK;
            end

            r_frame_tick <= w_tick_nxt;
        end
    end

    assign LoadReady = !r_pend_full;
    assign SegOut    = r_seg_out;
    assign DigEn     = r_dig_en;
    assign FrameTick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int NUM_DIG   = 2;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = NUM_DIG * DIV;

    logic        Clk;
    logic        Rst;
    logic [15:0] SegIn;
    logic        LoadValid;
    logic        LoadReady;
    logic [7:0]  SegOut;
    logic [1:0]  DigEn;
    logic        FrameTick;

    int tests_run = 0;
    int tests_failed = 0;

    seg7_scan_driver #(
        .NUM_DIG   (NUM_DIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .SegIn     (SegIn),
        .LoadValid (LoadValid),
        .LoadReady (LoadReady),
        .SegOut    (SegOut),
        .DigEn     (DigEn),
        .FrameTick (FrameTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position in the frame follows from elapsed cycles
    // since reset; buffers follow the handshake/frame-boundary rules.
    bit          m_valid = 0;
    int          m_t = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    bit          m_full = 0;

    int          e_ph, e_slot;
    bit          e_lit;
    logic [1:0]  e_de;
    logic [7:0]  e_seg;

    always @(negedge Clk) begin
        e_ph   = m_t % FRAME;
        e_slot = e_ph / DIV;
        e_lit  = (e_ph % DIV) >= BLANK_CYC;
        e_de   = e_lit ? (2'b01 << e_slot) : 2'b00;
        e_seg  = e_lit ? m_active[8*e_slot +: 8] : 8'h00;
        if (m_valid) begin
            chk("model_digen", {30'd0, DigEn}, {30'd0, e_de});
            chk("model_segout", {24'd0, SegOut}, {24'd0, e_seg});
            chk("model_frametick", {31'd0, FrameTick}, {31'd0, (e_ph == FRAME - 1)});
            chk("model_loadready", {31'd0, LoadReady}, {31'd0, !m_full});
            chk("digen_onehot0", {31'd0, ($countones(DigEn) > 1)}, 32'd0);
        end
        if (Rst) begin
            m_valid   = 1;
            m_t       = 0;
            m_active  = '0;
            m_pending = '0;
            m_full    = 0;
        end else if (m_valid) begin
            if (LoadValid && !m_full) begin
                m_pending = SegIn;
                m_full    = 1;
            end else if (e_ph == FRAME - 1 && m_full) begin
                m_active = m_pending;
                m_full   = 0;
            end
            m_t++;
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Advance at least one cycle, stopping on the given phase within a frame.
    task automatic go_to_phase(input int p);
        int g;
        g = 0;
        do begin
            next_cycle();
            g++;
        end while ((m_t % FRAME) != p && g < 3 * FRAME);
        if (g >= 3 * FRAME) chk("go_to_phase_timeout", 32'd1, 32'd0);
    endtask

    logic [1:0] rst_de  [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2};

    initial begin
        int f_a, g, n;
        Rst       = 1'b1;
        LoadValid = 1'b0;
        SegIn     = '0;
        repeat (3) next_cycle();
        Rst = 1'b0;

        // Reset release: 2 blank, 6 lit digit 0, 2 blank, digit 1
        for (int i = 0; i < 11; i++) begin
            @(negedge Clk);
            chk("rst_digen", {30'd0, DigEn}, {30'd0, rst_de[i]});
            chk("rst_segout", {24'd0, SegOut}, 32'd0);
            chk("rst_loadready", {31'd0, LoadReady}, 32'd1);
            next_cycle();
        end

        // Single load mid-frame
        go_to_phase(4);
        SegIn = 16'hF6C0;
        LoadValid = 1'b1;
        next_cycle();
        LoadValid = 1'b0;
        @(negedge Clk);
        chk("load_ready_drop", {31'd0, LoadReady}, 32'd0);
        go_to_phase(10);
        @(negedge Clk);
        chk("load_old_frame_seg", {24'd0, SegOut}, 32'h00);
        go_to_phase(15);
        @(negedge Clk);
        chk("load_tick", {31'd0, FrameTick}, 32'd1);
        chk("load_ready_at_tick", {31'd0, LoadReady}, 32'd0);
        next_cycle();
        @(negedge Clk);
        chk("load_ready_rise", {31'd0, LoadReady}, 32'd1);
        go_to_phase(2);
        @(negedge Clk);
        chk("load_dig0_seg", {24'd0, SegOut}, 32'hC0);
        chk("load_dig0_en", {30'd0, DigEn}, 32'd1);
        go_to_phase(10);
        @(negedge Clk);
        chk("load_dig1_seg", {24'd0, SegOut}, 32'hF6);
        chk("load_dig1_en", {30'd0, DigEn}, 32'd2);

        // Back-to-back loads
        go_to_phase(3);
        f_a = m_t / FRAME;
        SegIn = 16'h0101;
        LoadValid = 1'b1;
        next_cycle();
        SegIn = 16'h0202;
        g = 0;
        while (LoadReady !== 1'b1 && g < 3 * FRAME) begin
            next_cycle();
            g++;
        end
        chk("b2b_accept_cycle", m_t, (f_a + 1) * FRAME);
        next_cycle();
        LoadValid = 1'b0;
        go_to_phase(2);
        @(negedge Clk);
        chk("b2b_a_shown", {24'd0, SegOut}, 32'h01);
        go_to_phase(2);
        @(negedge Clk);
        chk("b2b_b_dig0", {24'd0, SegOut}, 32'h02);
        go_to_phase(10);
        @(negedge Clk);
        chk("b2b_b_dig1", {24'd0, SegOut}, 32'h02);

        // Boundary collision
        go_to_phase(4);
        SegIn = 16'h1234;
        LoadValid = 1'b1;
        next_cycle();
        LoadValid = 1'b0;
        go_to_phase(15);
        SegIn = 16'h5678;
        LoadValid = 1'b1;
        @(negedge Clk);
        chk("coll_tick", {31'd0, FrameTick}, 32'd1);
        chk("coll_not_ready", {31'd0, LoadReady}, 32'd0);
        next_cycle();
        @(negedge Clk);
        chk("coll_ready_next", {31'd0, LoadReady}, 32'd1);
        next_cycle();
        LoadValid = 1'b0;
        @(negedge Clk);
        chk("coll_accepted", {31'd0, LoadReady}, 32'd0);
        go_to_phase(2);
        @(negedge Clk);
        chk("coll_first_data", {24'd0, SegOut}, 32'h34);
        go_to_phase(2);
        @(negedge Clk);
        chk("coll_second_data", {24'd0, SegOut}, 32'h78);

        // Mid-frame reset with pending data
        go_to_phase(3);
        SegIn = 16'hAAAA;
        LoadValid = 1'b1;
        next_cycle();
        LoadValid = 1'b0;
        go_to_phase(10);
        Rst = 1'b1;
        @(negedge Clk);
        chk("mrst_dig1_lit", {30'd0, DigEn}, 32'd2);
        chk("mrst_pend_full", {31'd0, LoadReady}, 32'd0);
        next_cycle();
        Rst = 1'b0;
        @(negedge Clk);
        chk("mrst_digen", {30'd0, DigEn}, 32'd0);
        chk("mrst_segout", {24'd0, SegOut}, 32'd0);
        chk("mrst_ready", {31'd0, LoadReady}, 32'd1);
        go_to_phase(2);
        @(negedge Clk);
        chk("mrst_dig0_blank_data", {24'd0, SegOut}, 32'h00);
        chk("mrst_dig0_en", {30'd0, DigEn}, 32'd1);
        go_to_phase(2);
        @(negedge Clk);
        chk("mrst_next_frame_data", {24'd0, SegOut}, 32'h00);

        // Long run: FrameTick period over 100 frames
        g = 0;
        while (FrameTick !== 1'b1 && g < 2 * FRAME) begin
            next_cycle();
            g++;
        end
        chk("long_first_tick", {31'd0, FrameTick}, 32'd1);
        for (int k = 0; k < 100; k++) begin
            n = 0;
            do begin
                next_cycle();
                n++;
            end while (FrameTick !== 1'b1 && n < 2 * FRAME);
            chk("long_tick_period", n, FRAME);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver, downstream of the binary-to-segment decode stage. Accepts a full set of per-digit segment patterns over a valid/ready handshake and double-buffers them. Scans the digits one at a time onto a shared segment bus with a blanking guard between digits. New patterns are applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- `NUM_DIG`, default 4: number of digits scanned (≥1).
- `DIV`, default 50000: clock cycles per digit slot (blank + show).
- `BLANK_CYC`, default 16: blanking cycles at the start of each slot; 1 ≤ `BLANK_CYC` < `DIV`.
- `Clk`, input, 1: single clock; all logic is on the rising edge.
- `Rst`, input, 1: synchronous, active-high reset.
- `SegIn`, input, 8*NUM_DIG: segment patterns; digit k is `SegIn[8k+7:8k]`, bit order {a,b,c,d,e,f,g,dp}, 1 = segment lit.
- `LoadValid`, input, 1: `SegIn` is valid.
- `LoadReady`, output, 1: pending buffer is empty and can accept a load.
- `SegOut`, output, 8: segment bus, active-high.
- `DigEn`, output, NUM_DIG: one-hot digit enable, active-high; all-zero while blanking.
- `FrameTick`, output, 1: one-cycle pulse on the last cycle of digit NUM_DIG-1.

## Operation
- Registers:
  - `active` (8*NUM_DIG): the patterns being displayed.
  - `pending` (8*NUM_DIG) with `pend_full` flag.
  - `dig_idx`, width $clog2(NUM_DIG), minimum 1.
  - `cnt`, width $clog2(DIV).
  - `state`, one of {BLANK, SHOW}.
- Reset values:
  - `active` = 0, `pending` = 0, `pend_full` = 0.
  - `dig_idx` = 0, `cnt` = 0, `state` = BLANK.
  - Outputs: `LoadReady` = 1, `SegOut` = 0, `DigEn` = 0, `FrameTick` = 0.
- Load handshake:
  - A transfer occurs when `LoadValid & LoadReady` on a rising edge: `pending` ← `SegIn`, `pend_full` ← 1.
  - `LoadReady` = !`pend_full` (registered state, no combinational path from `LoadValid`).
  - `LoadValid` while `LoadReady` = 0 is ignored. The source must hold the data; nothing is dropped silently.
- Scan state machine:
  - `cnt` increments every cycle and wraps at DIV-1 → 0.
  - BLANK: `DigEn` = 0, `SegOut` = 0. Move to SHOW when `cnt` = BLANK_CYC-1.
  - SHOW: `DigEn` = 1<<`dig_idx`, `SegOut` = `active[8*dig_idx +: 8]`. When `cnt` = DIV-1, move to BLANK and advance `dig_idx` (NUM_DIG-1 wraps to 0).
- Frame boundary (SHOW, `cnt` = DIV-1, `dig_idx` = NUM_DIG-1):
  - `FrameTick` = 1.
  - If `pend_full`: `active` ← `pending`, `pend_full` ← 0.
- Simultaneous events:
  - A frame-boundary transfer and a load request in the same cycle: the load is not accepted, because `LoadReady` is still 0. `LoadReady` rises on the next cycle.
- Reset mid-frame: state returns to the reset values on the next edge and any pending data is discarded.

## Timing
- All outputs are registered from state (Moore). `SegOut` and `DigEn` change only on slot and phase boundaries.
- First cycle after `Rst` deasserts: BLANK, digit 0, `cnt` = 0.
- Per slot: exactly BLANK_CYC cycles blank, then DIV-BLANK_CYC cycles lit.
- Frame period: NUM_DIG*DIV cycles. `FrameTick` period equals the frame period.
- Load-to-display latency: from the accept edge to the first lit cycle of digit 0 in the next frame.
  - Minimum: BLANK_CYC+1 cycles, when accepted on the frame-boundary cycle minus 1.
  - Maximum: NUM_DIG*DIV + BLANK_CYC cycles.
- `LoadReady` is low from the cycle after accept through the frame-boundary cycle, inclusive.

## Structure
- Shared package `seg7_pkg`:
  - State enum `scan_state_t` {BLANK, SHOW}.
  - `SEG_W` = 8.
  - Constant `SEG_BLANK` = 8'h00.
  - Digit pattern constants shared with the decode stage.
- Sub-module `seg7_refresh_timer`, parameterised by `DIV` and `BLANK_CYC`. It owns `cnt` and produces `blank_end` (cnt = BLANK_CYC-1) and `slot_end` (cnt = DIV-1) strobes.
- The top level holds the buffers, `dig_idx`, the FSM and the output registers.

## Test plan
Bench parameters: NUM_DIG=2, DIV=8, BLANK_CYC=2.
- **Reset:** assert `Rst` for 3 cycles, then release. `SegOut` = 0 and `DigEn` = 0 for 2 cycles. Then `DigEn` = 01 with `SegOut` = 00 for 6 cycles, followed by 2 blank cycles and `DigEn` = 10. `LoadReady` = 1 throughout.
- **Single load:** drive `SegIn` = 16'hF6_C0 with `LoadValid` for 1 cycle mid-frame. `LoadReady` drops the next cycle. The current frame still shows 00/00. The next frame shows digit0 = C0 and digit1 = F6. `LoadReady` rises the cycle after `FrameTick`.
- **Back-to-back loads:** load A = 16'h0101, then hold `LoadValid` with B = 16'h0202. B is accepted on the cycle after the frame that applies A. A is displayed for one full frame, then B.
- **Boundary collision:** assert `LoadValid` exactly on the `FrameTick` cycle while `pend_full` = 1. No accept that cycle. Accepted on the next cycle.
- **Mid-frame reset:** assert `Rst` with `pend_full` = 1 while digit 1 is lit. Next cycle: `DigEn` = 0, `SegOut` = 0, `LoadReady` = 1. Following frames display 00/00.
- **Long run:** check that `FrameTick` fires every 16 cycles over 100 frames, and that `DigEn` is never multi-hot.
